// File: rtl/ws2811_decoder_pkg.sv
// rtl/ws2811_decoder_pkg.sv - shared WS2811 timing constants and decoder state encoding
// Timing values are in masterClk cycles at 50 MHz and are shared by encoder and decoder.
package ws2811_decoder_pkg;

    localparam int T0H_CYC            = 13;
    localparam int T1H_CYC            = 30;
    localparam int WS2811_THRESH_CYC  = 21;
    localparam int WS2811_TMIN_CYC    = 4;
    localparam int WS2811_TMAX_CYC    = 50;
    localparam int WS2811_TRESET_CYC  = 2500;
    localparam int WS2811_GLITCH_CYC  = 2;

    typedef enum logic [2:0] {
        ST_ALIGN = 3'd0,
        ST_IDLE  = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_STUCK = 3'd4
    } state_e;

endpackage

// File: rtl/ws2811_decoder_if.sv
// rtl/ws2811_decoder_if.sv - WS2811 decoder line input and decoded output bundle
// master: decoder side (reads wsIn, drives decoded outputs)
// slave : line driver / consumer side
interface ws2811_decoder_if #(
    parameter int BITCNT_W = 10
);
    logic                wsIn;
    logic                dataOut;
    logic                dataClk;
    logic                frameEnd;
    logic [BITCNT_W-1:0] bitCnt;
    logic                pulseErr;

    modport master (
        input  wsIn,
        output dataOut, dataClk, frameEnd, bitCnt, pulseErr
    );

    modport slave (
        output wsIn,
        input  dataOut, dataClk, frameEnd, bitCnt, pulseErr
    );
endinterface

// File: rtl/ws2811_line_sync.sv
// rtl/ws2811_line_sync.sv - 2-FF synchroniser, optional glitch filter, registered edge strobes
// Optional feature macro: WS2811_DECODER_GLITCH_FILTER_EN
// Ports: masterClk/nReset clock and sync active-low reset; ws_in async line;
//        ws_lvl registered line level; rise/fall one-cycle strobes aligned with ws_lvl.
module ws2811_line_sync
`ifdef WS2811_DECODER_GLITCH_FILTER_EN
#(
    parameter int GLITCH_CYC = 2
)
`endif
(
    input  logic masterClk,
    input  logic nReset,
    input  logic ws_in,
    output logic ws_lvl,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic rise_q,  rise_d;
    logic fall_q,  fall_d;
    logic ws_line;

`ifdef WS2811_DECODER_GLITCH_FILTER_EN
    logic       filt_q, filt_d;
    logic [7:0] gcnt_q, gcnt_d;

    // The filtered level flips only once the synchronised line has disagreed
    // with it for GLITCH_CYC consecutive samples; both edges see the same delay.
    always_comb begin
        filt_d = filt_q;
        gcnt_d = '0;
        if (sync2_q != filt_q) begin
            if (gcnt_q == 8'(GLITCH_CYC - 1)) begin
                filt_d = sync2_q;
            end else begin
                gcnt_d = gcnt_q + 8'd1;
            end
        end
    end

    assign ws_line = filt_q;
`else
    assign ws_line = sync2_q;
`endif

    // Strobes are registered together with prev_q so the FSM sees the strobe
    // in the first cycle of the new level.
    always_comb begin
        sync1_d = ws_in;
        sync2_d = sync1_q;
        prev_d  = ws_line;
        rise_d  = ws_line & ~prev_q;
        fall_d  = ~ws_line & prev_q;
    end

    always_ff @(posedge masterClk) begin
        if (!nReset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
`ifdef WS2811_DECODER_GLITCH_FILTER_EN
            filt_q  <= 1'b0;
            gcnt_q  <= '0;
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
`ifdef WS2811_DECODER_GLITCH_FILTER_EN
            filt_q  <= filt_d;
            gcnt_q  <= gcnt_d;
`endif
        end
    end

    assign ws_lvl = prev_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule

// File: rtl/ws2811_decoder.sv
// rtl/ws2811_decoder.sv - WS2811 800 kbps line decoder (pulse-width to dataOut/dataClk)
// Optional feature macro: WS2811_DECODER_GLITCH_FILTER_EN (input glitch filter)
// Ports: masterClk clock; nReset sync active-low reset;
//        bus.wsIn line in; bus.dataOut/dataClk decoded bit + strobe;
//        bus.frameEnd reset-gap strobe; bus.bitCnt bits this frame; bus.pulseErr bad pulse strobe.
module ws2811_decoder
    import ws2811_decoder_pkg::*;
#(
    parameter int THRESH_CYC = WS2811_THRESH_CYC,
    parameter int TMIN_CYC   = WS2811_TMIN_CYC,
    parameter int TMAX_CYC   = WS2811_TMAX_CYC,
    parameter int TRESET_CYC = WS2811_TRESET_CYC,
    parameter int CNT_W      = 12,
`ifdef WS2811_DECODER_GLITCH_FILTER_EN
    parameter int GLITCH_CYC = WS2811_GLITCH_CYC,
`endif
    parameter int BITCNT_W   = 10
) (
    input  logic                 masterClk,
    input  logic                 nReset,
    ws2811_decoder_if.master     bus
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH_CYC);
    localparam logic [CNT_W-1:0] TMIN_C   = CNT_W'(TMIN_CYC);
    localparam logic [CNT_W-1:0] STUCK_C  = CNT_W'(TMAX_CYC + 1);
    localparam logic [CNT_W-1:0] TRESET_C = CNT_W'(TRESET_CYC);

    logic ws_lvl, rise, fall;

    ws2811_line_sync
`ifdef WS2811_DECODER_GLITCH_FILTER_EN
    #(.GLITCH_CYC(GLITCH_CYC))
`endif
    u_line_sync (
        .masterClk (masterClk),
        .nReset    (nReset),
        .ws_in     (bus.wsIn),
        .ws_lvl    (ws_lvl),
        .rise      (rise),
        .fall      (fall)
    );

    state_e              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [BITCNT_W-1:0] bitCnt_q,   bitCnt_d;
    logic                dataOut_q,  dataOut_d;
    logic                dataClk_q,  dataClk_d;
    logic                frameEnd_q, frameEnd_d;
    logic                pulseErr_q, pulseErr_d;
    logic [CNT_W-1:0]    cnt_inc;

    always_ff @(posedge masterClk) begin
        if (!nReset) begin
            state_q    <= ST_ALIGN;
            cnt_q      <= '0;
            bitCnt_q   <= '0;
            dataOut_q  <= 1'b0;
            dataClk_q  <= 1'b0;
            frameEnd_q <= 1'b0;
            pulseErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitCnt_q   <= bitCnt_d;
            dataOut_q  <= dataOut_d;
            dataClk_q  <= dataClk_d;
            frameEnd_q <= frameEnd_d;
            pulseErr_q <= pulseErr_d;
        end
    end

    // cnt is set to 1 in the first cycle of a level, so at a fall strobe it
    // holds exactly the number of high cycles just ended.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitCnt_d   = bitCnt_q;
        dataOut_d  = dataOut_q;
        dataClk_d  = 1'b0;
        frameEnd_d = 1'b0;
        pulseErr_d = 1'b0;
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            ST_ALIGN: begin
                // Any high sample restarts the search for a full reset gap.
                if (ws_lvl) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TRESET_C) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (rise) begin
                    cnt_d   = 1;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    cnt_d   = 1;
                    state_d = ST_LOW;
                    if (cnt_q < TMIN_C) begin
                        pulseErr_d = 1'b1;
                    end else begin
                        dataOut_d = (cnt_q >= THRESH_C);
                        dataClk_d = 1'b1;
                        if (bitCnt_q != '1) begin
                            bitCnt_d = bitCnt_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == STUCK_C) begin
                        pulseErr_d = 1'b1;
                        state_d    = ST_STUCK;
                    end
                end
            end
            ST_STUCK: begin
                cnt_d = cnt_inc;
                if (fall) begin
                    cnt_d   = 1;
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                // A rise wins over a coincident reset-gap expiry.
                if (rise) begin
                    cnt_d   = 1;
                    state_d = ST_HIGH;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TRESET_C) begin
                        frameEnd_d = 1'b1;
                        bitCnt_d   = '0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_ALIGN;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.dataOut  = dataOut_q;
    assign bus.dataClk  = dataClk_q;
    assign bus.frameEnd = frameEnd_q;
    assign bus.bitCnt   = bitCnt_q;
    assign bus.pulseErr = pulseErr_q;

endmodule

// File: tb/tb_ws2811_decoder.sv
// tb/tb_ws2811_decoder.sv - directed self-checking bench for ws2811_decoder
module tb_ws2811_decoder;
    import ws2811_decoder_pkg::*;

`ifdef WS2811_DECODER_GLITCH_FILTER_EN
    localparam int G = WS2811_GLITCH_CYC;
`else
    localparam int G = 0;
`endif

    logic clk    = 1'b0;
    logic nReset = 1'b0;
    always #5 clk = ~clk;

    ws2811_decoder_if #(.BITCNT_W(10)) bus();

    ws2811_decoder dut (
        .masterClk (clk),
        .nReset    (nReset),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          n_clk   = 0;
    int          n_fe    = 0;
    int          n_err   = 0;
    int          clk_cyc = 0;
    int          fe_cyc  = 0;
    int          err_cyc = 0;
    logic [31:0] shreg      = '0;
    logic        last_bit   = 1'b0;
    logic [9:0]  prev_bc    = '0;
    logic [9:0]  fe_prev_bc = '0;

    int c0, f0, e0, k, hi;
    logic [23:0] pat;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.dataClk === 1'b1) begin
            n_clk    <= n_clk + 1;
            shreg    <= {shreg[30:0], bus.dataOut};
            last_bit <= bus.dataOut;
            clk_cyc  <= cyc;
        end
        if (bus.frameEnd === 1'b1) begin
            n_fe       <= n_fe + 1;
            fe_cyc     <= cyc;
            fe_prev_bc <= prev_bc;
        end
        if (bus.pulseErr === 1'b1) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
        end
        prev_bc <= bus.bitCnt;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        c0 = n_clk;
        f0 = n_fe;
        e0 = n_err;
    endtask

    task automatic pulse(input int h, input int l);
        bus.wsIn = 1'b1;
        tick(h);
        bus.wsIn = 1'b0;
        tick(l);
    endtask

    initial begin
        bus.wsIn = 1'b0;
        nReset   = 1'b0;
        tick(3);
        chk("rst_dataOut",  32'(bus.dataOut),  0);
        chk("rst_dataClk",  32'(bus.dataClk),  0);
        chk("rst_frameEnd", 32'(bus.frameEnd), 0);
        chk("rst_pulseErr", 32'(bus.pulseErr), 0);
        chk("rst_bitCnt",   32'(bus.bitCnt),   0);
        chk("rst_state",    32'(dut.state_q),  32'(ST_ALIGN));

        // Alignment: 2500 low cycles after reset release, no frameEnd.
        nReset = 1'b1;
        snap();
        tick(2499);
        chk("align_not_yet", 32'(dut.state_q), 32'(ST_ALIGN));
        tick(1);
        chk("align_idle",    32'(dut.state_q), 32'(ST_IDLE));
        chk("align_no_fe",   32'(n_fe - f0),   0);

        // First 13-cycle pulse: decodes 0, dataClk 4 (+filter) cycles after the fall.
        bus.wsIn = 1'b1;
        tick(13);
        bus.wsIn = 1'b0;
        k = cyc;
        tick(10);
        chk("t0_count",   32'(n_clk - c0),   1);
        chk("t0_bit",     32'(last_bit),     0);
        chk("t0_latency", 32'(clk_cyc - k),  32'(4 + G));
        chk("t0_bitcnt",  32'(bus.bitCnt),   1);
        chk("t0_no_err",  32'(n_err - e0),   0);
        tick(2600);
        chk("t0_fe",      32'(n_fe - f0),    1);
        chk("t0_fe_clr",  32'(bus.bitCnt),   0);

        // Encoder loopback of 0xA5C3F0, MSB first, 62-cycle bit period.
        pat = 24'hA5C3F0;
        snap();
        for (int i = 23; i >= 1; i--) begin
            hi = pat[i] ? T1H_CYC : T0H_CYC;
            pulse(hi, 62 - hi);
        end
        hi = pat[0] ? T1H_CYC : T0H_CYC;
        bus.wsIn = 1'b1;
        tick(hi);
        bus.wsIn = 1'b0;
        k = cyc;
        tick(2600);
        chk("lb_count",     32'(n_clk - c0),    24);
        chk("lb_data",      {8'h00, shreg[23:0]}, 32'h00A5C3F0);
        chk("lb_fe",        32'(n_fe - f0),     1);
        chk("lb_fe_lat",    32'(fe_cyc - k),    32'(2503 + G));
        chk("lb_bc_before", 32'(fe_prev_bc),    24);
        chk("lb_bc_after",  32'(bus.bitCnt),    0);
        chk("lb_no_err",    32'(n_err - e0),    0);

        // Threshold and width boundaries.
        snap();
        pulse(20, 40);
        chk("w20_bit",   32'(last_bit),    0);
        chk("w20_count", 32'(n_clk - c0),  1);
        pulse(21, 40);
        chk("w21_bit",   32'(last_bit),    1);
        chk("w21_count", 32'(n_clk - c0),  2);
        pulse(3, 40);
        chk("w3_err",    32'(n_err - e0),  1);
        chk("w3_no_clk", 32'(n_clk - c0),  2);
        pulse(4, 40);
        chk("w4_bit",    32'(last_bit),    0);
        chk("w4_count",  32'(n_clk - c0),  3);
        pulse(50, 40);
        chk("w50_bit",   32'(last_bit),    1);
        chk("w50_count", 32'(n_clk - c0),  4);
        chk("w50_err",   32'(n_err - e0),  1);
        chk("w_bitcnt",  32'(bus.bitCnt),  4);

        // Stuck high for 200 cycles, then a reset gap.
        snap();
        bus.wsIn = 1'b1;
        k = cyc;
        tick(200);
        bus.wsIn = 1'b0;
        tick(2600);
        chk("stuck_err",    32'(n_err - e0),   1);
        chk("stuck_errcyc", 32'(err_cyc - k),  32'(54 + G));
        chk("stuck_no_clk", 32'(n_clk - c0),   0);
        chk("stuck_fe",     32'(n_fe - f0),    1);

        // Reset in the middle of a 30-cycle pulse.
        pulse(30, 32);
        pulse(30, 32);
        chk("pre_rst_bc",  32'(bus.bitCnt),  2);
        chk("pre_rst_bit", 32'(bus.dataOut), 1);
        bus.wsIn = 1'b1;
        tick(10);
        nReset = 1'b0;
        tick(1);
        chk("mid_rst_dataOut", 32'(bus.dataOut),  0);
        chk("mid_rst_bitCnt",  32'(bus.bitCnt),   0);
        chk("mid_rst_state",   32'(dut.state_q),  32'(ST_ALIGN));
        nReset = 1'b1;
        snap();
        tick(19);
        bus.wsIn = 1'b0;
        tick(100);
        pulse(30, 40);
        chk("mid_rst_no_clk", 32'(n_clk - c0),  0);
        chk("mid_rst_no_err", 32'(n_err - e0),  0);
        chk("mid_rst_align",  32'(dut.state_q), 32'(ST_ALIGN));
        tick(2500);
        chk("mid_rst_idle",   32'(dut.state_q), 32'(ST_IDLE));
        chk("mid_rst_no_fe",  32'(n_fe - f0),   0);
        pulse(30, 40);
        chk("post_rst_clk",   32'(n_clk - c0),  1);
        chk("post_rst_bit",   32'(last_bit),    1);
        chk("post_rst_bc",    32'(bus.bitCnt),  1);

`ifdef WS2811_DECODER_GLITCH_FILTER_EN
        // One-cycle spikes in a low period vanish; a 30-cycle pulse still decodes as 1.
        snap();
        for (int i = 0; i < 3; i++) begin
            pulse(1, 20);
        end
        chk("spike_no_err", 32'(n_err - e0), 0);
        chk("spike_no_clk", 32'(n_clk - c0), 0);
        bus.wsIn = 1'b1;
        tick(30);
        bus.wsIn = 1'b0;
        k = cyc;
        tick(20);
        chk("filt_clk",     32'(n_clk - c0),  1);
        chk("filt_bit",     32'(last_bit),    1);
        chk("filt_latency", 32'(clk_cyc - k), 32'(4 + G));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ws2811_decoder.md
Name: ws2811_decoder

Overview:
- Receive-side counterpart of the WS2811 encoder. Recovers the bit stream from a WS2811-modulated 800 kbps line.
- Measures each high-pulse width in masterClk cycles and classifies it as 0 or 1.
- Presents the result as a dataOut/dataClk pair, the same unmodulated form the encoder consumes. Also flags frame ends (reset/latch gaps) and malformed pulses.
- Sits at the satellite's WS2811 input pin; used for loopback self-test and for daisy-chain monitoring.

Parameters:
- THRESH_CYC, 21: high width >= THRESH_CYC decodes as 1, else 0. At 50 MHz: T0H ~13 cyc, T1H ~30 cyc.
- TMIN_CYC, 4: high width < TMIN_CYC is a glitch/error.
- TMAX_CYC, 50: high width > TMAX_CYC is a stuck-high error.
- TRESET_CYC, 2500: low time >= TRESET_CYC (50 us) is a frame end.
- CNT_W, 12: width counter bits; must hold TRESET_CYC.
- BITCNT_W, 10: bits-in-frame counter width.
- GLITCH_CYC, 2: filter depth, used only with the optional feature.

Ports:
- masterClk  in  1  master clock, >= 30 MHz; all logic on posedge.
- nReset  in  1  synchronous, active-low reset.
- wsIn  in  1  WS2811 line, asynchronous to masterClk.
- dataOut  out  1  decoded bit; valid while dataClk = 1, held until the next decode.
- dataClk  out  1  one-cycle high strobe per decoded bit.
- frameEnd  out  1  one-cycle strobe on a detected reset gap.
- bitCnt  out  BITCNT_W  bits decoded since the last frameEnd; saturates at all-ones.
- pulseErr  out  1  one-cycle strobe on a too-short or too-long high pulse.

Behaviour:
- Reset: nReset = 0 sampled on a masterClk posedge → dataOut = 0, dataClk = 0, frameEnd = 0, pulseErr = 0, bitCnt = 0, cnt = 0, synchroniser = 0, state = ALIGN. Applies mid-pulse: any partial measurement is discarded.
- Input path: wsIn goes through a 2-FF synchroniser to wsSync. A previous-sample register gives rise/fall strobes on wsSync.
- cnt increments every cycle in HIGH and LOW and saturates at all-ones. It clears to 1 on each edge, so it counts the current level's cycles inclusively.
- States:
  - ALIGN: wait for wsSync low for TRESET_CYC consecutive cycles, then go to IDLE with no frameEnd pulse. A rise restarts the low count.
  - IDLE: on a rise → HIGH.
  - HIGH:
    - Fall with TMIN_CYC <= cnt <= TMAX_CYC → next cycle dataOut = (cnt >= THRESH_CYC), dataClk = 1, bitCnt += 1 (saturating); go to LOW.
    - Fall with cnt < TMIN_CYC → pulseErr = 1, no dataClk; go to LOW.
    - cnt reaching TMAX_CYC + 1 while high → pulseErr = 1 once; go to STUCK.
  - STUCK: on a fall → LOW, with no dataClk and no further error.
  - LOW:
    - Rise → HIGH.
    - cnt reaching TRESET_CYC → frameEnd = 1 for one cycle, bitCnt cleared to 0 on the same edge; go to IDLE.
- Latency: wsIn fall to dataClk is 4 masterClk cycles (2 sync + 1 edge + 1 output register). wsIn low to frameEnd is TRESET_CYC + 3 cycles.
- Simultaneous events: frameEnd and dataClk never coincide, since they come from different states. A rise in the same cycle that cnt reaches TRESET_CYC is treated as a rise, so no frameEnd.
- Back-to-back bits need no minimum low time beyond one wsSync sample. A decode always completes before the next rise can be processed.

Optional Feature:
- Macro: WS2811_DECODER_GLITCH_FILTER_EN.
- Defined: a filter between the synchroniser and the edge detector. wsFilt changes only after wsSync has held the new value for GLITCH_CYC consecutive cycles.
  - Pulses shorter than GLITCH_CYC are suppressed entirely.
  - Both edges are delayed equally, so measured widths are preserved.
  - Latency grows by GLITCH_CYC.
- Undefined: wsSync feeds the edge detector directly.

Decomposition:
- Shared env header `genericIOSateliteEnv.v` holds the timing defines used by both encoder and decoder: T0H_CYC, T1H_CYC, WS2811_THRESH_CYC, WS2811_TMIN_CYC, WS2811_TMAX_CYC, WS2811_TRESET_CYC. Parameter defaults derive from these defines.
- Also in the header: state encodings ALIGN, IDLE, HIGH, LOW, STUCK.
- One sub-module: ws2811_line_sync (synchroniser, optional glitch filter, edge strobes).

Test Plan:
- Reset, then hold wsIn = 0 for 2500 cycles → no frameEnd, state IDLE. A 13-cycle high pulse → dataClk = 1, dataOut = 0 exactly 4 cycles after the fall; bitCnt = 1.
- Encoder loopback, 24 bits 0xA5C3F0, then 2600 cycles low → 24 dataClk strobes reproducing 0xA5C3F0 MSB-first, then frameEnd; bitCnt reads 24 just before frameEnd and 0 after it.
- Thresholds: high widths 20 and 21 cycles → dataOut 0 and 1 respectively. Width 3 → pulseErr, no dataClk. Width 4 → decodes as 0.
- Stuck high for 200 cycles → a single pulseErr at cycle 51 of the high level, no dataClk. Then low 2500 cycles → frameEnd.
- Assert nReset mid-pulse (cycle 10 of a 30-cycle high) → all outputs 0 next cycle. The decoder requires a full 2500-cycle low before decoding again, and the remaining high produces no output.
- With WS2811_DECODER_GLITCH_FILTER_EN defined: 1-cycle spikes inside a low period → ignored, no pulseErr. A 30-cycle pulse → decodes as 1 with latency 4 + GLITCH_CYC.
